dbx_decompressor: RTL

- Sequential inverse of the encoder-side DBX symbol stage. It parses one variable-length DBX/ZRLE symbol per handshake from a left-aligned bit window supplied by the upstream unpacker, and reports how many bits were consumed.
- It expands each symbol, including multi-plane zero runs, into delta bit-planes. It reconstructs each DBP from the running XOR chain.
- It emits DATA_W+1 planes per block, in index order DATA_W down to 0, to the delta-reconstruction stage.

---
 rtl/dbx_decompressor.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dbx_decompressor.sv
// DBX/ZRLE symbol decoder: parses one variable-length symbol per handshake and
// rebuilds delta bit-planes through a running XOR chain, index DATA_W down to 0.
package ebpc_pkg;
  localparam int DATA_W       = 8;
  localparam int BLOCK_SIZE   = 8;
  localparam int MAX_SYMB_LEN = BLOCK_SIZE;
  localparam int LOG2N        = $clog2(BLOCK_SIZE);
  localparam int ZRL_W        = $clog2(DATA_W);
endpackage

module dbx_decompressor
  import ebpc_pkg::*;
(
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [MAX_SYMB_LEN-1:0]           sym_i,
  input  logic                              sym_valid_i,
  output logic                              sym_ready_o,
  output logic [$clog2(MAX_SYMB_LEN+1)-1:0] sym_len_o,
  output logic [BLOCK_SIZE-2:0]             dbp_o,
  output logic [$clog2(DATA_W+1)-1:0]       dbp_idx_o,
  output logic                              dbp_last_o,
  output logic                              dbp_valid_o,
  input  logic                              dbp_ready_i,
  output logic                              err_o,
  output logic                              dbg_state,
  output logic [$clog2(DATA_W+1)-1:0]       dbg_run_cnt
);
  localparam int PW = BLOCK_SIZE - 1;
  localparam int IW = $clog2(DATA_W + 1);
  localparam int LW = $clog2(MAX_SYMB_LEN + 1);
  localparam logic [IW-1:0] TOP_IDX = IW'(DATA_W);
  localparam logic [IW-1:0] ONE     = IW'(1);
  localparam logic [IW:0]   ONE_W   = (IW+1)'(1);

  typedef enum logic {DEC = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  logic [PW-1:0] prev;
  logic [IW-1:0] plane_cnt;
  logic [IW-1:0] run_cnt;

  logic [PW-1:0]    dbx;
  logic             force_zero;
  logic [IW:0]      run_len;
  logic [LOG2N-1:0] pos;

  assign pos = sym_i[MAX_SYMB_LEN-6 -: LOG2N];

  always_comb begin
    dbx        = '0;
    force_zero = 1'b0;
    run_len    = '0;
    sym_len_o  = LW'(5);
    if (sym_i[MAX_SYMB_LEN-1]) begin
      dbx       = sym_i[PW-1:0];
      sym_len_o = LW'(BLOCK_SIZE);
    end else if (sym_i[MAX_SYMB_LEN-2]) begin
      run_len   = (IW+1)'(sym_i[MAX_SYMB_LEN-3 -: ZRL_W]) + (IW+1)'(2);
      sym_len_o = LW'(2 + ZRL_W);
    end else if (sym_i[MAX_SYMB_LEN-3]) begin
      run_len   = ONE_W;
      sym_len_o = LW'(3);
    end else begin
      // Bits shifted past the LSB are the "outside the plane" positions.
      case (sym_i[MAX_SYMB_LEN-4 -: 2])
        2'b00:   force_zero = 1'b1;
        2'b01:   dbx = '1;
        2'b11: begin
          dbx       = {1'b1, {(PW-1){1'b0}}} >> pos;
          sym_len_o = LW'(5 + LOG2N);
        end
        default: begin
          dbx       = {2'b11, {(PW-2){1'b0}}} >> pos;
          sym_len_o = LW'(5 + LOG2N);
        end
      endcase
    end
  end

  // Handshakes: a transfer happens in a cycle where valid && ready are both high;
  // the producer keeps valid and payload stable until that cycle.
  logic          out_free, accept, load, ovf;
  logic [PW-1:0] prev_eff, plane;
  logic [IW:0]   remaining, run_take;

  assign out_free    = !dbp_valid_o || dbp_ready_i;
  assign sym_ready_o = (state == DEC) && out_free;
  assign accept      = sym_valid_i && sym_ready_o;
  assign load        = accept || ((state == RUN) && out_free);
  assign prev_eff    = (plane_cnt == TOP_IDX) ? '0 : prev;
  assign remaining   = {1'b0, plane_cnt} + ONE_W;
  assign ovf         = run_len > remaining;
  assign run_take    = ovf ? remaining : run_len;
  assign plane       = ((state == RUN) || force_zero) ? (force_zero && state == DEC ? '0 : prev_eff)
                                                      : (dbx ^ prev_eff);
  assign dbg_state   = state;
  assign dbg_run_cnt = run_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= DEC;
      prev        <= '0;
      plane_cnt   <= TOP_IDX;
      run_cnt     <= '0;
      dbp_o       <= '0;
      dbp_idx_o   <= TOP_IDX;
      dbp_last_o  <= 1'b0;
      dbp_valid_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      // Registered, so the pulse lines up with the first plane of a truncated run.
      err_o <= accept && ovf;
      if (dbp_valid_o && dbp_ready_i) dbp_valid_o <= 1'b0;
      if (load) begin
        dbp_o       <= plane;
        dbp_idx_o   <= plane_cnt;
        dbp_last_o  <= (plane_cnt == '0);
        dbp_valid_o <= 1'b1;
        prev        <= plane;
        plane_cnt   <= (plane_cnt == '0) ? TOP_IDX : plane_cnt - ONE;
      end
      case (state)
        DEC: begin
          if (accept && run_take > ONE_W) begin
            run_cnt <= IW'(run_take - ONE_W);
            state   <= RUN;
          end
        end
        RUN: begin
          if (out_free) begin
            run_cnt <= run_cnt - ONE;
            if (run_cnt == ONE) state <= DEC;
          end
        end
        default: state <= DEC;
      endcase
    end
  end
endmodule
